// File: rtl/des_round_key_sequencer.sv
// des_round_key_sequencer: iterative DES key schedule streaming K1..K16 (or K16..K1 when DES_KS_DECRYPT_EN is defined)
module des_round_key_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic [63:0] key,
   input  logic        decrypt,
   output logic        rk_valid,
   input  logic        rk_ready,
   output logic [47:0] round_key,
   output logic [3:0]  round_idx,
   output logic        rk_last,
   output logic        busy,
   input  logic        abort
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_T[i]];
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
      return r;
   endfunction

   // r is the zero-based round number; rounds 1, 2, 9 and 16 rotate by one, all others by two
   function automatic logic two_shift(input logic [3:0] r);
      return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
   endfunction

   function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
      return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
   endfunction

   logic [0:0]  state_q, state_d;
   logic [27:0] c_q, c_d, d_q, d_d, c_step, d_step;
   logic [3:0]  idx_q, idx_d, idx_step;
   logic        dec_q, dec_d, dec_in;
   logic [55:0] pc1_k;
   logic        unused_parity;

   assign pc1_k = pc1(key);
   assign unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

`ifdef DES_KS_DECRYPT_EN
   function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
      return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
   endfunction
   assign dec_in   = decrypt;
   assign c_step   = dec_q ? rotr(c_q, two_shift(idx_q)) : rotl(c_q, two_shift(idx_q + 4'd1));
   assign d_step   = dec_q ? rotr(d_q, two_shift(idx_q)) : rotl(d_q, two_shift(idx_q + 4'd1));
   assign idx_step = dec_q ? idx_q - 4'd1 : idx_q + 4'd1;
`else
   logic unused_decrypt;
   assign unused_decrypt = decrypt;
   assign dec_in   = 1'b0;
   assign c_step   = rotl(c_q, two_shift(idx_q + 4'd1));
   assign d_step   = rotl(d_q, two_shift(idx_q + 4'd1));
   assign idx_step = idx_q + 4'd1;
`endif

   assign key_ready = state_q == IDLE;
   assign busy      = state_q == RUN;
   assign rk_valid  = state_q == RUN;
   assign round_key = pc2({c_q, d_q});
   assign round_idx = idx_q;
   assign rk_last   = (state_q == RUN) && (idx_q == (dec_q ? 4'd0 : 4'd15));

   // load C/D on key accept, advance one round per handshake, flush on abort
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      idx_d   = idx_q;
      dec_d   = dec_q;
      if (state_q == IDLE) begin
         if (key_valid) begin
            state_d = RUN;
            dec_d   = dec_in;
            c_d     = dec_in ? pc1_k[55:28] : rotl(pc1_k[55:28], 1'b0);
            d_d     = dec_in ? pc1_k[27:0] : rotl(pc1_k[27:0], 1'b0);
            idx_d   = dec_in ? 4'd15 : 4'd0;
         end
      end else if (abort) begin
         state_d = IDLE;
         c_d     = '0;
         d_d     = '0;
         idx_d   = '0;
         dec_d   = 1'b0;
      end else if (rk_ready) begin
         if (rk_last) begin
            state_d = IDLE;
         end else begin
            c_d   = c_step;
            d_d   = d_step;
            idx_d = idx_step;
         end
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         idx_q   <= '0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         idx_q   <= idx_d;
         dec_q   <= dec_d;
      end
   end
endmodule

// File: tb/tb_des_round_key_sequencer.sv
// tb_des_round_key_sequencer: scoreboard bench with a cumulative-rotation DES key schedule model
module tb_des_round_key_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic [63:0] key = '0;
   logic        decrypt = 1'b0;
   logic        rk_valid;
   logic        rk_ready = 1'b0;
   logic [47:0] round_key;
   logic [3:0]  round_idx;
   logic        rk_last;
   logic        busy;
   logic        abort = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   logic [52:0] exp_q[$];

   localparam logic [63:0] TV_KEY = 64'h133457799BBCDFF1;
   localparam logic [47:0] TV_K1  = 48'h1B02EFFC7072;
   localparam logic [47:0] TV_K16 = 48'hCB3D8B0E17F5;

   localparam int M_PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int M_PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   des_round_key_sequencer dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
      .decrypt(decrypt), .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
      .round_idx(round_idx), .rk_last(rk_last), .busy(busy), .abort(abort));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // round key n (1..16): C0/D0 rotated left by the total of all shifts up to round n, then PC-2
   function automatic logic [47:0] model_key(input logic [63:0] k, input int n);
      logic [55:0] cd;
      logic [55:0] cc;
      logic [55:0] dd;
      logic [47:0] r;
      int tot;
      for (int i = 0; i < 56; i++) cd[55-i] = k[64-M_PC1[i]];
      tot = 0;
      for (int j = 1; j <= n; j++) tot += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
      cc = {cd[55:28], cd[55:28]} >> (28 - tot);
      dd = {cd[27:0], cd[27:0]} >> (28 - tot);
      cd = {cc[27:0], dd[27:0]};
      for (int i = 0; i < 48; i++) r[47-i] = cd[56-M_PC2[i]];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_seq(input logic [63:0] k, input logic dec);
      logic d;
      int r;
`ifdef DES_KS_DECRYPT_EN
      d = dec;
`else
      d = 1'b0 & dec;
`endif
      for (int i = 0; i < 16; i++) begin
         r = d ? 16 - i : i + 1;
         exp_q.push_back({model_key(k, r), 4'(r - 1), i == 15});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [63:0] k, input logic dec);
      int i;
      key = k;
      decrypt = dec;
      key_valid = 1'b1;
      for (i = 0; i < 100 && key_ready !== 1'b1; i++) tick();
      chk("key_ready_wait", {63'd0, key_ready}, 64'd1);
      push_seq(k, dec);
      tick();
      key_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit rnd);
      int i;
      for (i = 0; i < 300 && key_ready !== 1'b1; i++) begin
         rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
      end
      chk("idle_reached", {63'd0, key_ready}, 64'd1);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_idx(input logic [3:0] v);
      int i;
      for (i = 0; i < 40 && round_idx !== v; i++) tick();
      chk("reach_idx", {60'd0, round_idx}, {60'd0, v});
   endtask

   // monitor: pops on each handshake, checks the pending key against the queue head while stalled
   always @(negedge clk) begin
      if (!rst && !abort && rk_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_key", {11'd0, round_key, round_idx, rk_last}, 64'd0);
         end else if (rk_ready === 1'b1) begin
            chk("handshake_key", {11'd0, round_key, round_idx, rk_last}, {11'd0, exp_q.pop_front()});
         end else begin
            chk("stall_hold", {11'd0, round_key, round_idx, rk_last}, {11'd0, exp_q[0]});
         end
      end
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_key_ready", {63'd0, key_ready}, 64'd1);
      chk("rst_rk_valid", {63'd0, rk_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_round_key", {16'd0, round_key}, 64'd0);
      chk("rst_round_idx", {60'd0, round_idx}, 64'd0);
      chk("rst_rk_last", {63'd0, rk_last}, 64'd0);

      rk_ready = 1'b1;
      send_key(TV_KEY, 1'b0);
      chk("enc_first_valid", {63'd0, rk_valid}, 64'd1);
      chk("enc_first_key", {16'd0, round_key}, {16'd0, TV_K1});
      chk("enc_first_idx", {60'd0, round_idx}, 64'd0);
      chk("enc_ready_low", {63'd0, key_ready}, 64'd0);
      repeat (15) tick();
      chk("enc_last_key", {16'd0, round_key}, {16'd0, TV_K16});
      chk("enc_last_idx", {60'd0, round_idx}, 64'd15);
      chk("enc_last_flag", {63'd0, rk_last}, 64'd1);
      tick();
      chk("enc_back_idle", {62'd0, key_ready, rk_valid}, 64'd2);
      chk("enc_queue_empty", 64'(exp_q.size()), 64'd0);

      send_key(TV_KEY, 1'b1);
`ifdef DES_KS_DECRYPT_EN
      chk("dec_first_key", {16'd0, round_key}, {16'd0, TV_K16});
      chk("dec_first_idx", {60'd0, round_idx}, 64'd15);
      repeat (15) tick();
      chk("dec_last_key", {16'd0, round_key}, {16'd0, TV_K1});
      chk("dec_last_idx", {60'd0, round_idx}, 64'd0);
`else
      chk("nodec_first_key", {16'd0, round_key}, {16'd0, TV_K1});
      chk("nodec_first_idx", {60'd0, round_idx}, 64'd0);
      repeat (15) tick();
      chk("nodec_last_key", {16'd0, round_key}, {16'd0, TV_K16});
      chk("nodec_last_idx", {60'd0, round_idx}, 64'd15);
`endif
      chk("dec_last_flag", {63'd0, rk_last}, 64'd1);
      wait_idle(1'b0);

      for (int n = 0; n < 13; n++) begin
         rk_ready = 1'($urandom_range(0, 1));
         send_key({$urandom, $urandom}, 1'($urandom_range(0, 1)));
         wait_idle(1'b1);
      end

      rk_ready = 1'b1;
      send_key({$urandom, $urandom}, 1'b0);
      wait_idx(4'd7);
      rk_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      chk("rst_run_rk_valid", {63'd0, rk_valid}, 64'd0);
      chk("rst_run_key_ready", {63'd0, key_ready}, 64'd1);
      chk("rst_run_round_idx", {60'd0, round_idx}, 64'd0);
      rk_ready = 1'b1;
      send_key(TV_KEY, 1'b0);
      chk("after_rst_k1", {16'd0, round_key}, {16'd0, TV_K1});
      wait_idle(1'b0);

      rk_ready = 1'b1;
      send_key({$urandom, $urandom}, 1'b0);
      key_valid = 1'b1;
      key = {$urandom, $urandom};
      for (int i = 0; i < 40 && round_idx !== 4'd3; i++) begin
         chk("run_key_ready_low", {63'd0, key_ready}, 64'd0);
         tick();
      end
      chk("abort_at_idx3", {60'd0, round_idx}, 64'd3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      key_valid = 1'b0;
      exp_q.delete();
      chk("abort_idle", {62'd0, key_ready, rk_valid}, 64'd2);
      chk("abort_idx_clr", {60'd0, round_idx}, 64'd0);
      repeat (3) begin
         tick();
         chk("abort_no_valid", {63'd0, rk_valid}, 64'd0);
      end

      rk_ready = 1'b0;
      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
